// File: rtl/audio_mix_n.sv
// N-channel audio mixer: snapshot, per-channel gain/mute, sequential sum,
// saturation to the output width, signed and offset-binary outputs.
module audio_mix_n #(
   parameter int CHANNELS   = 4,
   parameter int IN_BITS    = 14,
   parameter int OUT_BITS   = 16,
   parameter int GAIN_BITS  = 4,
   parameter int SAMPLE_DIV = 1000
) (
   input  logic                          clk_i,
   input  logic                          res_n_i,
   input  logic [CHANNELS*IN_BITS-1:0]   ch_data_i,
   input  logic [CHANNELS*GAIN_BITS-1:0] ch_gain_i,
   input  logic [CHANNELS-1:0]           ch_mute_i,
   output logic [OUT_BITS-1:0]           mix_o,
   output logic [OUT_BITS-1:0]           mix_u_o,
   output logic                          sample_o,
   output logic                          clip_o
);

   localparam int PW = IN_BITS + GAIN_BITS + 1;
   localparam int AW = PW + $clog2(CHANNELS);
   localparam int RW = AW + OUT_BITS - IN_BITS;
   localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(CHANNELS - 1);

   localparam logic signed [RW-1:0] MAXV =
      {{(RW-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
   localparam logic signed [RW-1:0] MINV =
      {{(RW-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      SCALE
   } state_t;

   state_t                         state;
   logic [DW-1:0]                  div;
   logic                           tick;
   logic [IW-1:0]                  idx;
   logic signed [AW-1:0]           acc;
   logic [CHANNELS*IN_BITS-1:0]    snap_data;
   logic [CHANNELS*GAIN_BITS-1:0]  snap_gain;
   logic [CHANNELS-1:0]            snap_mute;

   logic [IN_BITS-1:0]             cur_d;
   logic [GAIN_BITS-1:0]           cur_g;
   logic signed [IN_BITS-1:0]      s;
   logic signed [PW-1:0]           prod;
   logic signed [AW-1:0]           shifted;
   logic signed [RW-1:0]           r;
   logic                           clip_hi;
   logic                           clip_lo;
   logic [OUT_BITS-1:0]            sat;

   assign tick = (div == DIV_LAST);

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         div <= '0;
      end else if (tick) begin
         div <= '0;
      end else begin
         div <= div + 1'b1;
      end
   end

   // Offset-binary to signed is an MSB flip; mute forces a zero term.
   always_comb begin
      cur_d = snap_data[idx*IN_BITS +: IN_BITS];
      cur_g = snap_gain[idx*GAIN_BITS +: GAIN_BITS];
      s     = {~cur_d[IN_BITS-1], cur_d[IN_BITS-2:0]};
      prod  = '0;
      if (!snap_mute[idx]) begin
         prod = PW'(s) * PW'($signed({1'b0, cur_g}));
      end
   end

   always_comb begin
      shifted = acc >>> (GAIN_BITS - 1);
      r       = RW'(shifted) <<< (OUT_BITS - IN_BITS);
      clip_hi = (r > MAXV);
      clip_lo = (r < MINV);
      sat     = r[OUT_BITS-1:0];
      if (clip_hi) begin
         sat = {1'b0, {(OUT_BITS-1){1'b1}}};
      end else if (clip_lo) begin
         sat = {1'b1, {(OUT_BITS-1){1'b0}}};
      end
   end

   always_ff @(posedge clk_i or negedge res_n_i) begin
      if (!res_n_i) begin
         state     <= IDLE;
         idx       <= '0;
         acc       <= '0;
         snap_data <= '0;
         snap_gain <= '0;
         snap_mute <= '0;
         mix_o     <= '0;
         mix_u_o   <= {1'b1, {(OUT_BITS-1){1'b0}}};
         clip_o    <= 1'b0;
         sample_o  <= 1'b0;
      end else begin
         sample_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (tick) begin
                  snap_data <= ch_data_i;
                  snap_gain <= ch_gain_i;
                  snap_mute <= ch_mute_i;
                  acc       <= '0;
                  idx       <= '0;
                  state     <= ACC;
               end
            end
            ACC: begin
               acc <= acc + AW'(prod);
               idx <= idx + 1'b1;
               if (idx == IDX_LAST) begin
                  state <= SCALE;
               end
            end
            SCALE: begin
               mix_o    <= sat;
               mix_u_o  <= {~sat[OUT_BITS-1], sat[OUT_BITS-2:0]};
               clip_o   <= clip_hi | clip_lo;
               sample_o <= 1'b1;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // A tick outside IDLE would drop a sample.
   a_tick_idle: assert property (
      @(posedge clk_i) disable iff (!res_n_i)
      tick |-> (state == IDLE)
   );

endmodule

// File: tb/tb_audio_mix_n.sv
// Randomised scoreboard bench for audio_mix_n against an arithmetic model.
module tb_audio_mix_n;

   localparam int CH = 4;
   localparam int IB = 14;
   localparam int OB = 16;
   localparam int GB = 4;
   localparam int SD = 16;
   localparam int MID = 1 << (IB - 1);

   logic                 clk_i = 1'b0;
   logic                 res_n_i = 1'b0;
   logic [CH*IB-1:0]     ch_data_i = '0;
   logic [CH*GB-1:0]     ch_gain_i = '0;
   logic [CH-1:0]        ch_mute_i = '0;
   logic [OB-1:0]        mix_o;
   logic [OB-1:0]        mix_u_o;
   logic                 sample_o;
   logic                 clip_o;

   audio_mix_n #(
      .CHANNELS  (CH),
      .IN_BITS   (IB),
      .OUT_BITS  (OB),
      .GAIN_BITS (GB),
      .SAMPLE_DIV(SD)
   ) dut (
      .clk_i    (clk_i),
      .res_n_i  (res_n_i),
      .ch_data_i(ch_data_i),
      .ch_gain_i(ch_gain_i),
      .ch_mute_i(ch_mute_i),
      .mix_o    (mix_o),
      .mix_u_o  (mix_u_o),
      .sample_o (sample_o),
      .clip_o   (clip_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int mix;
      int clip;
      int due;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nbad = 0;
   int   ecnt = 0;
   int   last_strobe = -1;
   int   nstrobe = 0;

   task automatic chk(input string nm, input int act, input int want);
      nvec++;
      if (act != want) begin
         nbad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, want);
      end
   endtask

   function automatic exp_t model(input logic [CH*IB-1:0] d,
                                  input logic [CH*GB-1:0] g,
                                  input logic [CH-1:0] m);
      exp_t e;
      int acc = 0;
      int r;
      int maxv = (1 << (OB - 1)) - 1;
      int minv = -(1 << (OB - 1));
      for (int k = 0; k < CH; k++) begin
         int sv = int'(d[k*IB +: IB]) - MID;
         int gv = m[k] ? 0 : int'(g[k*GB +: GB]);
         acc += sv * gv;
      end
      r = (acc >>> (GB - 1)) * (1 << (OB - IB));
      e.clip = 0;
      e.mix  = r;
      if (r > maxv) begin
         e.mix  = maxv;
         e.clip = 1;
      end else if (r < minv) begin
         e.mix  = minv;
         e.clip = 1;
      end
      e.due = 0;
      return e;
   endfunction

   // Reference timing: a sample is taken every SD edges after reset release
   // and appears CH+1 edges after the snapshot edge.
   initial begin
      forever begin
         @(posedge clk_i);
         if (!res_n_i) begin
            q.delete();
            ecnt = 0;
            last_strobe = -1;
         end else begin
            ecnt++;
            if (ecnt % SD == 0) begin
               exp_t e;
               e = model(ch_data_i, ch_gain_i, ch_mute_i);
               e.due = ecnt + CH + 1;
               q.push_back(e);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk_i);
         if (res_n_i && sample_o) begin
            nstrobe++;
            if (q.size() == 0) begin
               chk("unexpected_strobe", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("strobe_edge", ecnt, e.due);
               chk("mix", int'($signed(mix_o)), e.mix);
               chk("mix_u", int'(mix_u_o), e.mix + (1 << (OB - 1)));
               chk("clip", int'(clip_o), e.clip);
               if (last_strobe >= 0) begin
                  chk("strobe_period", ecnt - last_strobe, SD);
               end
               last_strobe = ecnt;
            end
         end
      end
   end

   task automatic drive(input int d[CH], input int g[CH],
                        input logic [CH-1:0] m, input int hold);
      @(negedge clk_i);
      for (int k = 0; k < CH; k++) begin
         ch_data_i[k*IB +: IB] = IB'(d[k]);
         ch_gain_i[k*GB +: GB] = GB'(g[k]);
      end
      ch_mute_i = m;
      repeat (hold - 1) @(negedge clk_i);
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 2 * SD && (ecnt % SD != 0 || ecnt == 0); i++) begin
         @(negedge clk_i);
      end
      chk("tick_wait", ecnt % SD, 0);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, "_mix"}, int'(mix_o), 0);
      chk({nm, "_mix_u"}, int'(mix_u_o), 1 << (OB - 1));
      chk({nm, "_clip"}, int'(clip_o), 0);
      chk({nm, "_sample"}, int'(sample_o), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d[CH];
      int g[CH];
      logic [CH-1:0] m;

      for (int k = 0; k < CH; k++) begin
         ch_data_i[k*IB +: IB] = IB'(MID);
         ch_gain_i[k*GB +: GB] = GB'(8);
      end
      repeat (3) @(negedge clk_i);
      chk_reset_vals("reset");
      res_n_i = 1'b1;

      drive('{MID, MID, MID, MID}, '{8, 8, 8, 8}, '0, 2 * SD + 6);
      drive('{16383, MID, MID, MID}, '{8, 8, 8, 8}, '0, SD);
      drive('{16383, 16383, MID, MID}, '{8, 8, 8, 8}, '0, SD);
      drive('{0, 0, 0, 0}, '{15, 15, 15, 15}, '0, SD);
      drive('{16383, 16383, MID, MID}, '{8, 8, 8, 8}, 4'b0010, SD);
      drive('{16383, 16383, MID, MID}, '{0, 8, 8, 8}, 4'b0010, SD);

      // Change ch0 right after a snapshot: only the next sample sees it.
      drive('{16383, MID, MID, MID}, '{8, 8, 8, 8}, '0, SD);
      wait_tick();
      ch_data_i[0 +: IB] = '0;
      repeat (2 * SD) @(negedge clk_i);

      // Reset in the middle of accumulation.
      wait_tick();
      @(negedge clk_i);
      res_n_i = 1'b0;
      #1;
      chk_reset_vals("midreset");
      repeat (3) @(negedge clk_i);
      chk("midreset_hold_sample", int'(sample_o), 0);
      res_n_i = 1'b1;

      for (int n = 0; n < 40; n++) begin
         for (int k = 0; k < CH; k++) begin
            case ($urandom_range(0, 3))
               0: d[k] = 0;
               1: d[k] = (1 << IB) - 1;
               2: d[k] = MID;
               default: d[k] = int'($urandom_range(0, (1 << IB) - 1));
            endcase
            g[k] = int'($urandom_range(0, (1 << GB) - 1));
            m[k] = ($urandom_range(0, 3) == 0);
         end
         drive(d, g, m, int'($urandom_range(1, 24)));
      end

      repeat (2 * SD + CH + 4) @(negedge clk_i);
      chk("drain", q.size(), 0);
      chk("strobes_seen", int'(nstrobe > 20), 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
